dmem_responder: RTL and testbench

- Data-memory responder at the far end of the memory-stage request interface.
- Accepts the M-stage request (address = ALUResultM, store data = WriteDataM, MemWriteM, load strobe, funct3 size).
- Performs byte/half/word little-endian stores and sign/zero-extending loads.
- Returns registered read data and a fault flag aligned to the W stage: one-cycle latency, same timing as the M/W pipeline register.

---
 rtl/dmem_responder.sv | 137 +++++++++++++
 tb/tb_dmem_responder.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder
//   Data-memory responder at the far end of the M-stage request interface.
//   Performs little-endian byte/half/word stores and sign/zero-extending loads.
//   Load data and the fault flag come out registered with one cycle of latency,
//   lined up with the M/W pipeline register.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset (outputs only, array is kept)
//   MemWriteM    store request this cycle
//   MemReadM     load request this cycle (ignored when MemWriteM is also set)
//   Funct3M      size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   ALUResultM   byte address (only the low ADDR_WIDTH bits are used)
//   WriteDataM   store data, right-justified
//   StallW       hold ReadDataW / FaultW
//   ReadDataW    extended load data
//   FaultW       previous request was misaligned or used an illegal funct3
//   FaultSticky  set on any fault, cleared only by rst
//
// The byte lanes are laid out for a 32-bit data path.

module dmem_responder #(
    parameter int    DATA_WIDTH = 32,
    parameter int    ADDR_WIDTH = 17,
    parameter string MEM_INIT   = ""
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MemWriteM,
    input  logic                  MemReadM,
    input  logic [2:0]            Funct3M,
    input  logic [DATA_WIDTH-1:0] ALUResultM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    input  logic                  StallW,
    output logic [DATA_WIDTH-1:0] ReadDataW,
    output logic                  FaultW,
    output logic                  FaultSticky
);

    localparam int MEM_BYTES = 2 ** ADDR_WIDTH;

    logic [7:0] mem_q [0:MEM_BYTES-1];

    logic [ADDR_WIDTH-1:0] addr0, addr1, addr2, addr3;
    logic [1:0]            size;
    logic                  store_legal, load_legal, misaligned;
    logic                  load_req, store_fault, load_fault, store_ok;
    logic [7:0]            rb0, rb1, rb2, rb3;
    logic [DATA_WIDTH-1:0] load_data;

    logic [DATA_WIDTH-1:0] read_data_q, read_data_d;
    logic                  fault_q, fault_d;
    logic                  sticky_q, sticky_d;

    // Upper address bits are deliberately ignored: the array wraps.
    logic unused_addr_bits;
    assign unused_addr_bits = ^ALUResultM[DATA_WIDTH-1:ADDR_WIDTH];

    always_comb begin
        addr0 = ALUResultM[ADDR_WIDTH-1:0];
        addr1 = addr0 + ADDR_WIDTH'(1);
        addr2 = addr0 + ADDR_WIDTH'(2);
        addr3 = addr0 + ADDR_WIDTH'(3);
        size  = Funct3M[1:0];

        store_legal = (Funct3M == 3'b000) || (Funct3M == 3'b001) || (Funct3M == 3'b010);
        load_legal  = store_legal || (Funct3M == 3'b100) || (Funct3M == 3'b101);
        misaligned  = ((size == 2'b01) && addr0[0]) ||
                      ((size == 2'b10) && (addr0[1:0] != 2'b00));

        // A simultaneous store and load is treated as a store only.
        load_req    = MemReadM && !MemWriteM;
        store_fault = MemWriteM && (!store_legal || misaligned);
        load_fault  = load_req && (!load_legal || misaligned);
        store_ok    = MemWriteM && !store_fault && !rst;
    end

    // Reads are combinational from the array so a load right after a store
    // to the same location sees the freshly written bytes.
    always_comb begin
        rb0 = mem_q[addr0];
        rb1 = mem_q[addr1];
        rb2 = mem_q[addr2];
        rb3 = mem_q[addr3];
        load_data = '0;
        case (Funct3M)
            3'b000:  load_data = {{(DATA_WIDTH-8){rb0[7]}}, rb0};
            3'b001:  load_data = {{(DATA_WIDTH-16){rb1[7]}}, rb1, rb0};
            3'b010:  load_data = DATA_WIDTH'({rb3, rb2, rb1, rb0});
            3'b100:  load_data = {{(DATA_WIDTH-8){1'b0}}, rb0};
            3'b101:  load_data = {{(DATA_WIDTH-16){1'b0}}, rb1, rb0};
            default: load_data = '0;
        endcase
    end

    // Stores ignore StallW; re-presenting the same store is harmless.
    always_ff @(posedge clk) begin
        if (store_ok) begin
            mem_q[addr0] <= WriteDataM[7:0];
            if (size != 2'b00) begin
                mem_q[addr1] <= WriteDataM[15:8];
            end
            if (size == 2'b10) begin
                mem_q[addr2] <= WriteDataM[23:16];
                mem_q[addr3] <= WriteDataM[31:24];
            end
        end
    end

    always_comb begin
        read_data_d = read_data_q;
        fault_d     = fault_q;
        if (!StallW) begin
            read_data_d = (load_req && !load_fault) ? load_data : '0;
            fault_d     = store_fault || load_fault;
        end
        // Store faults are recorded even while W is stalled.
        sticky_d = sticky_q || store_fault || (load_fault && !StallW);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            read_data_q <= '0;
            fault_q     <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            read_data_q <= read_data_d;
            fault_q     <= fault_d;
            sticky_q    <= sticky_d;
        end
    end

    assign ReadDataW   = read_data_q;
    assign FaultW      = fault_q;
    assign FaultSticky = sticky_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    logic        clk;
    logic        rst;
    logic        MemWriteM;
    logic        MemReadM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic        StallW;
    logic [31:0] ReadDataW;
    logic        FaultW;
    logic        FaultSticky;

    dmem_responder #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(17),
        .MEM_INIT  ("")
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .MemWriteM  (MemWriteM),
        .MemReadM   (MemReadM),
        .Funct3M    (Funct3M),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .StallW     (StallW),
        .ReadDataW  (ReadDataW),
        .FaultW     (FaultW),
        .FaultSticky(FaultSticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] rd;
        logic        flt;
        logic        stk;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   edge_n = 0;
    int   checks = 0;
    int   errors = 0;

    localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;

    // Monitor: after every rising edge, compare outputs against every expectation due now.
    initial begin
        forever begin
            @(posedge clk);
            edge_n++;
            #2;
            while (sb.size() > 0 && sb[0].due <= edge_n) begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                if (ReadDataW !== e.rd || FaultW !== e.flt || FaultSticky !== e.stk) begin
                    errors++;
                    $display("FAIL %s: got rd=%08h fault=%b sticky=%b, want rd=%08h fault=%b sticky=%b",
                             e.name, ReadDataW, FaultW, FaultSticky, e.rd, e.flt, e.stk);
                end
            end
        end
    end

    task automatic step(input logic we, input logic re, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic stall, input logic r,
                        input logic [31:0] erd, input logic ef, input logic es,
                        input string name);
        exp_t e;
        @(negedge clk);
        MemWriteM  = we;
        MemReadM   = re;
        Funct3M    = f3;
        ALUResultM = addr;
        WriteDataM = wdata;
        StallW     = stall;
        rst        = r;
        e.due  = edge_n + 1;
        e.rd   = erd;
        e.flt  = ef;
        e.stk  = es;
        e.name = name;
        sb.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; MemWriteM = 1'b0; MemReadM = 1'b0; Funct3M = W;
        ALUResultM = '0; WriteDataM = '0; StallW = 1'b0;

        //    we    re    f3  addr          wdata         stl   rst   exp_rd        flt   stk
        step(1'b0, 1'b0, W,  32'h0,        32'h0,        1'b0, 1'b1, 32'h0,        1'b0, 1'b0, "reset");
        step(1'b1, 1'b0, W,  32'h100,      32'hDEADBEEF, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, "sw_100");
        step(1'b0, 1'b1, W,  32'h100,      32'h0,        1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, "lw_100");
        step(1'b1, 1'b0, B,  32'h101,      32'h0000005A, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, "sb_101");
        step(1'b0, 1'b1, W,  32'h100,      32'h0,        1'b0, 1'b0, 32'hDEAD5AEF, 1'b0, 1'b0, "lw_after_sb");
        step(1'b0, 1'b1, B,  32'h103,      32'h0,        1'b0, 1'b0, 32'hFFFFFFDE, 1'b0, 1'b0, "lb_103");
        step(1'b0, 1'b1, BU, 32'h103,      32'h0,        1'b0, 1'b0, 32'h000000DE, 1'b0, 1'b0, "lbu_103");
        step(1'b1, 1'b0, H,  32'h102,      32'h00008001, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, "sh_102");
        step(1'b0, 1'b1, H,  32'h102,      32'h0,        1'b0, 1'b0, 32'hFFFF8001, 1'b0, 1'b0, "lh_102");
        step(1'b0, 1'b1, HU, 32'h102,      32'h0,        1'b0, 1'b0, 32'h00008001, 1'b0, 1'b0, "lhu_102");
        step(1'b0, 1'b1, W,  32'h102,      32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b1, "lw_misaligned");
        step(1'b1, 1'b0, H,  32'h101,      32'h0000BEEF, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, "sh_misaligned");
        step(1'b0, 1'b1, W,  32'h100,      32'h0,        1'b0, 1'b0, 32'h80015AEF, 1'b0, 1'b1, "lw_unchanged");
        // Stall: outputs hold the previous load, then update after release
        step(1'b0, 1'b1, BU, 32'h100,      32'h0,        1'b1, 1'b0, 32'h80015AEF, 1'b0, 1'b1, "stall_hold1");
        step(1'b0, 1'b1, BU, 32'h100,      32'h0,        1'b1, 1'b0, 32'h80015AEF, 1'b0, 1'b1, "stall_hold2");
        step(1'b0, 1'b1, BU, 32'h100,      32'h0,        1'b1, 1'b0, 32'h80015AEF, 1'b0, 1'b1, "stall_hold3");
        step(1'b0, 1'b1, BU, 32'h100,      32'h0,        1'b0, 1'b0, 32'h000000EF, 1'b0, 1'b1, "stall_release");
        // Fault flag holds across a stall, clears on a following idle
        step(1'b0, 1'b1, H,  32'h103,      32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b1, "lh_misaligned");
        step(1'b0, 1'b0, W,  32'h0,        32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 1'b1, "fault_hold");
        step(1'b0, 1'b0, W,  32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b1, "idle_clear");
        // Illegal funct3 on load and store
        step(1'b0, 1'b1, 3'b011, 32'h100,  32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b1, "ld_illegal_f3");
        step(1'b1, 1'b0, BU, 32'h100,      32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b1, "st_illegal_f3");
        step(1'b0, 1'b1, W,  32'h100,      32'h0,        1'b0, 1'b0, 32'h80015AEF, 1'b0, 1'b1, "lw_after_illegal");
        // Store and load together act as a store
        step(1'b1, 1'b1, W,  32'h104,      32'h11223344, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, "st_and_ld");
        step(1'b0, 1'b1, W,  32'h104,      32'h0,        1'b0, 1'b0, 32'h11223344, 1'b0, 1'b1, "lw_104");
        // Reset suppresses a store in the same cycle; earlier stores persist
        step(1'b1, 1'b0, W,  32'h200,      32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b1, "sw0_200");
        step(1'b1, 1'b0, W,  32'h200,      32'h12345678, 1'b0, 1'b1, 32'h0,        1'b0, 1'b0, "rst_with_sw");
        step(1'b0, 1'b1, W,  32'h200,      32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, "lw_200_after_rst");
        step(1'b0, 1'b1, W,  32'h100,      32'h0,        1'b0, 1'b0, 32'h80015AEF, 1'b0, 1'b0, "persist_100");
        // Address wrap modulo 2^17 and more extension cases
        step(1'b1, 1'b0, W,  32'h00020300, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, "sw_wrap");
        step(1'b0, 1'b1, W,  32'h300,      32'h0,        1'b0, 1'b0, 32'hCAFEF00D, 1'b0, 1'b0, "lw_300");
        step(1'b0, 1'b1, H,  32'h302,      32'h0,        1'b0, 1'b0, 32'hFFFFCAFE, 1'b0, 1'b0, "lh_302");
        step(1'b0, 1'b1, HU, 32'h300,      32'h0,        1'b0, 1'b0, 32'h0000F00D, 1'b0, 1'b0, "lhu_300");
        step(1'b0, 1'b1, B,  32'h301,      32'h0,        1'b0, 1'b0, 32'hFFFFFFF0, 1'b0, 1'b0, "lb_301");
        step(1'b0, 1'b0, W,  32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, "idle_end");

        repeat (3) @(posedge clk);
        #3;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
